// File: rtl/jtdd_gfx_arb.sv
// Purpose : shares one graphics ROM read port between CHAR, SCR and OBJ fetchers, each with a one-entry cache.
// Latency : from a new address to x_ok takes at least 3 cycles (grant, ack+dok, ok); one IDLE cycle separates fetches.
// Backpress: rom_req is held with a stable rom_addr until rom_ack; a fetch in flight always completes and cannot be aborted.
//
// Ports:
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   char_cs/char_addr -> char_data/char_ok   char client: request, address, cached data, data valid
//   scr_cs/scr_addr   -> scr_data/scr_ok     scroll client
//   obj_cs/obj_addr   -> obj_data/obj_ok     object client
//   rom_addr, rom_req                downstream address (client addr + base) and request
//   rom_ack, rom_dok, rom_data       downstream accept pulse, data-valid pulse, read data
module jtdd_gfx_arb #(
  parameter int                CHAR_AW  = 15,
  parameter int                SCR_AW   = 17,
  parameter int                OBJ_AW   = 18,
  parameter int                ROM_AW   = 22,
  parameter int                DW       = 8,
  parameter logic [ROM_AW-1:0] CHAR_OFS = 22'h00000,
  parameter logic [ROM_AW-1:0] SCR_OFS  = 22'h08000,
  parameter logic [ROM_AW-1:0] OBJ_OFS  = 22'h28000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               char_cs,
  input  logic [CHAR_AW-1:0] char_addr,
  output logic [DW-1:0]      char_data,
  output logic               char_ok,
  input  logic               scr_cs,
  input  logic [SCR_AW-1:0]  scr_addr,
  output logic [DW-1:0]      scr_data,
  output logic               scr_ok,
  input  logic               obj_cs,
  input  logic [OBJ_AW-1:0]  obj_addr,
  output logic [DW-1:0]      obj_data,
  output logic               obj_ok,
  output logic [ROM_AW-1:0]  rom_addr,
  output logic               rom_req,
  input  logic               rom_ack,
  input  logic               rom_dok,
  input  logic [DW-1:0]      rom_data
);

  // Fetch address register is wide enough for the widest client.
  localparam int FAW_CS = (CHAR_AW > SCR_AW) ? CHAR_AW : SCR_AW;
  localparam int FAW    = (FAW_CS > OBJ_AW) ? FAW_CS : OBJ_AW;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DATA} state_t;
  typedef enum logic [1:0] {G_CHAR, G_SCR, G_OBJ} gnt_t;

  state_t             r_state;
  gnt_t               r_gnt;
  logic [FAW-1:0]     r_faddr;

  logic               r_char_vld;
  logic               r_scr_vld;
  logic               r_obj_vld;
  logic [CHAR_AW-1:0] r_char_last;
  logic [SCR_AW-1:0]  r_scr_last;
  logic [OBJ_AW-1:0]  r_obj_last;
  logic [DW-1:0]      r_char_data;
  logic [DW-1:0]      r_scr_data;
  logic [DW-1:0]      r_obj_data;
  logic               r_rom_req;
  logic [ROM_AW-1:0]  r_rom_addr;

  logic               w_char_hit;
  logic               w_scr_hit;
  logic               w_obj_hit;
  logic               w_char_pend;
  logic               w_scr_pend;
  logic               w_obj_pend;
  logic               w_store;

  assign w_char_hit  = r_char_vld && (r_char_last == char_addr);
  assign w_scr_hit   = r_scr_vld  && (r_scr_last  == scr_addr);
  assign w_obj_hit   = r_obj_vld  && (r_obj_last  == obj_addr);

  assign w_char_pend = char_cs && !w_char_hit;
  assign w_scr_pend  = scr_cs  && !w_scr_hit;
  assign w_obj_pend  = obj_cs  && !w_obj_hit;

  // Data arriving in REQ (with or without ack) or in DATA completes the fetch.
  assign w_store = rom_dok && ((r_state == ST_REQ) || (r_state == ST_DATA));

  assign char_ok   = char_cs && w_char_hit;
  assign scr_ok    = scr_cs  && w_scr_hit;
  assign obj_ok    = obj_cs  && w_obj_hit;
  assign char_data = r_char_data;
  assign scr_data  = r_scr_data;
  assign obj_data  = r_obj_data;
  assign rom_req   = r_rom_req;
  assign rom_addr  = r_rom_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_gnt       <= G_CHAR;
      r_faddr     <= '0;
      r_char_vld  <= 1'b0;
      r_scr_vld   <= 1'b0;
      r_obj_vld   <= 1'b0;
      r_char_last <= '0;
      r_scr_last  <= '0;
      r_obj_last  <= '0;
      r_char_data <= '0;
      r_scr_data  <= '0;
      r_obj_data  <= '0;
      r_rom_req   <= 1'b0;
      r_rom_addr  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Downstream pulses seen here belong to nothing and are dropped.
          if (w_char_pend) begin
            r_gnt      <= G_CHAR;
            r_faddr    <= FAW'(char_addr);
            r_rom_addr <= ROM_AW'(char_addr) + CHAR_OFS;
            r_rom_req  <= 1'b1;
            r_state    <= ST_REQ;
          end else if (w_scr_pend) begin
            r_gnt      <= G_SCR;
            r_faddr    <= FAW'(scr_addr);
            r_rom_addr <= ROM_AW'(scr_addr) + SCR_OFS;
            r_rom_req  <= 1'b1;
            r_state    <= ST_REQ;
          end else if (w_obj_pend) begin
            r_gnt      <= G_OBJ;
            r_faddr    <= FAW'(obj_addr);
            r_rom_addr <= ROM_AW'(obj_addr) + OBJ_OFS;
            r_rom_req  <= 1'b1;
            r_state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          // An early dok implies the request was taken.
          if (rom_ack || rom_dok) begin
            r_rom_req <= 1'b0;
            r_state   <= rom_dok ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (rom_dok) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_rom_req <= 1'b0;
        end
      endcase

      // Result is filed under the address that was fetched, not the client's
      // current one, so a moved client never sees stale data as ok.
      if (w_store) begin
        case (r_gnt)
          G_CHAR: begin
            r_char_data <= rom_data;
            r_char_last <= r_faddr[CHAR_AW-1:0];
            r_char_vld  <= 1'b1;
          end
          G_SCR: begin
            r_scr_data <= rom_data;
            r_scr_last <= r_faddr[SCR_AW-1:0];
            r_scr_vld  <= 1'b1;
          end
          G_OBJ: begin
            r_obj_data <= rom_data;
            r_obj_last <= r_faddr[OBJ_AW-1:0];
            r_obj_vld  <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtdd_gfx_arb.sv
module tb_jtdd_gfx_arb;

  logic        clk;
  logic        rst_n;
  logic        char_cs;
  logic [14:0] char_addr;
  logic [7:0]  char_data;
  logic        char_ok;
  logic        scr_cs;
  logic [16:0] scr_addr;
  logic [7:0]  scr_data;
  logic        scr_ok;
  logic        obj_cs;
  logic [17:0] obj_addr;
  logic [7:0]  obj_data;
  logic        obj_ok;
  logic [21:0] rom_addr;
  logic        rom_req;
  logic        rom_ack;
  logic        rom_dok;
  logic [7:0]  rom_data;

  int n_tests;
  int n_fail;

  jtdd_gfx_arb #(
    .OBJ_OFS (22'h3F0000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .char_cs   (char_cs),
    .char_addr (char_addr),
    .char_data (char_data),
    .char_ok   (char_ok),
    .scr_cs    (scr_cs),
    .scr_addr  (scr_addr),
    .scr_data  (scr_data),
    .scr_ok    (scr_ok),
    .obj_cs    (obj_cs),
    .obj_addr  (obj_addr),
    .obj_data  (obj_data),
    .obj_ok    (obj_ok),
    .rom_addr  (rom_addr),
    .rom_req   (rom_req),
    .rom_ack   (rom_ack),
    .rom_dok   (rom_dok),
    .rom_data  (rom_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait for rom_req (bounded), check the address, then ack after ack_dly
  // cycles and deliver data dok_dly cycles after the ack (0 = same cycle).
  task automatic serve(input string tag, input logic [21:0] exp_addr,
                       input int ack_dly, input int dok_dly, input logic [7:0] d);
    bit held;
    for (int i = 0; i < 20 && !rom_req; i++) tick();
    check({tag, "_req"}, {31'd0, rom_req}, 32'd1);
    check({tag, "_addr"}, {10'd0, rom_addr}, {10'd0, exp_addr});
    held = 1'b1;
    for (int i = 0; i < ack_dly; i++) begin
      tick();
      if (!(rom_req === 1'b1 && rom_addr === exp_addr)) held = 1'b0;
    end
    check({tag, "_held"}, {31'd0, held}, 32'd1);
    rom_ack = 1'b1;
    if (dok_dly == 0) begin
      rom_dok  = 1'b1;
      rom_data = d;
    end
    tick();
    rom_ack = 1'b0;
    rom_dok = 1'b0;
    check({tag, "_req_drop"}, {31'd0, rom_req}, 32'd0);
    if (dok_dly > 0) begin
      for (int i = 1; i < dok_dly; i++) tick();
      rom_dok  = 1'b1;
      rom_data = d;
      tick();
      rom_dok  = 1'b0;
    end
  endtask

  initial begin
    bit quiet;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    char_cs   = 1'b0;
    char_addr = '0;
    scr_cs    = 1'b0;
    scr_addr  = '0;
    obj_cs    = 1'b0;
    obj_addr  = '0;
    rom_ack   = 1'b0;
    rom_dok   = 1'b0;
    rom_data  = '0;
    repeat (3) tick();

    // Reset state
    check("rst_req",  {31'd0, rom_req}, 32'd0);
    check("rst_addr", {10'd0, rom_addr}, 32'd0);
    check("rst_oks",  {29'd0, char_ok, scr_ok, obj_ok}, 32'd0);
    check("rst_data", {8'd0, char_data, scr_data, obj_data}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: single char fetch, ack after 2, dok 3 later
    char_cs   = 1'b1;
    char_addr = 15'h0123;
    tick();
    check("t1_ok_pre", {31'd0, char_ok}, 32'd0);
    serve("t1", 22'h000123, 2, 3, 8'hA5);
    check("t1_ok",   {31'd0, char_ok}, 32'd1);
    check("t1_data", {24'd0, char_data}, 32'h0A5);
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rom_req !== 1'b0 || char_ok !== 1'b1) quiet = 1'b0;
    end
    check("t1_stable_no_req", {31'd0, quiet}, 32'd1);

    // 2: three simultaneous requests, priority CHAR > SCR > OBJ
    char_addr = 15'h0200;
    scr_cs    = 1'b1;
    scr_addr  = 17'h01234;
    obj_cs    = 1'b1;
    obj_addr  = 18'h00456;
    tick();
    serve("t2_char", 22'h000200, 0, 1, 8'h11);
    check("t2_char_ok", {29'd0, char_ok, scr_ok, obj_ok}, 32'b100);
    check("t2_char_data", {24'd0, char_data}, 32'h11);
    serve("t2_scr", 22'h009234, 1, 1, 8'h22);
    check("t2_scr_ok", {29'd0, char_ok, scr_ok, obj_ok}, 32'b110);
    check("t2_scr_data", {24'd0, scr_data}, 32'h22);
    serve("t2_obj", 22'h3F0456, 0, 2, 8'h33);
    check("t2_obj_ok", {29'd0, char_ok, scr_ok, obj_ok}, 32'b111);
    check("t2_obj_data", {24'd0, obj_data}, 32'h33);

    // 3: char address moves during DATA of its fetch
    char_addr = 15'h0010;
    tick();
    for (int i = 0; i < 20 && !rom_req; i++) tick();
    check("t3_addr0", {10'd0, rom_addr}, 32'h000010);
    rom_ack = 1'b1;
    tick();
    rom_ack   = 1'b0;
    char_addr = 15'h0011;
    tick();
    rom_dok  = 1'b1;
    rom_data = 8'h5A;
    tick();
    rom_dok = 1'b0;
    check("t3_old_not_ok", {31'd0, char_ok}, 32'd0);
    serve("t3_new", 22'h000011, 1, 1, 8'h6B);
    check("t3_new_ok",   {31'd0, char_ok}, 32'd1);
    check("t3_new_data", {24'd0, char_data}, 32'h6B);

    // 4: ack and dok in the same cycle
    char_addr = 15'h0020;
    tick();
    serve("t4", 22'h000020, 0, 0, 8'h77);
    check("t4_ok",   {31'd0, char_ok}, 32'd1);
    check("t4_data", {24'd0, char_data}, 32'h77);
    tick();
    check("t4_no_stuck_req", {31'd0, rom_req}, 32'd0);

    // 5: reset pulse while in REQ
    obj_addr = 18'h00100;
    tick();
    for (int i = 0; i < 20 && !rom_req; i++) tick();
    check("t5_req_before", {31'd0, rom_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_req_async", {31'd0, rom_req}, 32'd0);
    check("t5_oks_clear", {29'd0, char_ok, scr_ok, obj_ok}, 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    serve("t5_char", 22'h000020, 0, 1, 8'h81);
    serve("t5_scr",  22'h009234, 0, 1, 8'h82);
    serve("t5_obj",  22'h3F0100, 0, 1, 8'h83);
    check("t5_oks", {29'd0, char_ok, scr_ok, obj_ok}, 32'b111);
    check("t5_data", {8'd0, char_data, scr_data, obj_data}, 32'h818283);

    // Downstream pulses while IDLE are ignored
    rom_dok  = 1'b1;
    rom_ack  = 1'b1;
    rom_data = 8'hEE;
    tick();
    rom_dok = 1'b0;
    rom_ack = 1'b0;
    tick();
    check("idle_dok_ignored", {8'd0, char_data, scr_data, obj_data}, 32'h818283);
    check("idle_no_req", {31'd0, rom_req}, 32'd0);

    // dok in REQ without ack counts as ack+dok
    char_addr = 15'h0030;
    tick();
    for (int i = 0; i < 20 && !rom_req; i++) tick();
    check("early_dok_req", {31'd0, rom_req}, 32'd1);
    rom_dok  = 1'b1;
    rom_data = 8'h99;
    tick();
    rom_dok = 1'b0;
    check("early_dok_req_drop", {31'd0, rom_req}, 32'd0);
    check("early_dok_ok", {31'd0, char_ok}, 32'd1);
    check("early_dok_data", {24'd0, char_data}, 32'h99);

    // 6: object address wraps modulo 2^22
    obj_addr = 18'h3FFFF;
    tick();
    serve("t6", 22'h02FFFF, 1, 2, 8'hC3);
    check("t6_ok",   {31'd0, obj_ok}, 32'd1);
    check("t6_data", {24'd0, obj_data}, 32'hC3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
